// File: rtl/i2c_slave_block.sv
// i2c_slave_block: 7-bit address I2C slave with synchronized, glitch-filtered SCL/SDA.
// Optional clock stretching is enabled by defining I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave_block #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic       i2c_core_clock_i,
  input  logic       reset_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_taken_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_full_i,
  output logic       busy_o,
  output logic       addressed_o,
  output logic       rw_o
);

  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // Bit 0 carries SCL, bit 1 carries SDA through every stage.
  logic [1:0]      sync_p0, sync_p1, filt_p2, filt_p3;
  logic [1:0][3:0] filt_cnt;

  always_ff @(posedge i2c_core_clock_i) begin
    if (reset_i) begin
      sync_p0  <= 2'b11;
      sync_p1  <= 2'b11;
      filt_p2  <= 2'b11;
      filt_p3  <= 2'b11;
      filt_cnt <= '0;
    end else begin
      sync_p0 <= {sda_i, scl_i};
      sync_p1 <= sync_p0;
      filt_p3 <= filt_p2;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt_p2[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_LAST) begin
          filt_p2[i]  <= sync_p1[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Stage p3: bus events from filtered level vs. its one-cycle-delayed copy
  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall, start_evt, stop_evt;

  assign scl_f     = filt_p2[0];
  assign sda_f     = filt_p2[1];
  assign scl_d     = filt_p3[0];
  assign sda_d     = filt_p3[1];
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_evt = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_evt  = scl_f & scl_d & ~sda_d & sda_f;

  state_t     state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt, rx_data_nxt, byte_in;
  logic       sda_oe_q, sda_oe_nxt, scl_oe_q, scl_oe_nxt;
  logic       busy_nxt, addressed_nxt, rw_nxt, rx_valid_nxt, tx_taken_nxt;
  logic       nack, nack_nxt, pend, pend_nxt;

  assign byte_in  = {shreg[6:0], sda_f};
  assign sda_oe_o = sda_oe_q;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  assign scl_oe_o = scl_oe_q;
`else
  assign scl_oe_o = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    rx_data_nxt   = rx_data_o;
    sda_oe_nxt    = sda_oe_q;
    scl_oe_nxt    = scl_oe_q;
    busy_nxt      = busy_o;
    addressed_nxt = addressed_o;
    rw_nxt        = rw_o;
    nack_nxt      = nack;
    pend_nxt      = pend;
    rx_valid_nxt  = 1'b0;
    tx_taken_nxt  = 1'b0;
    if (start_evt || stop_evt) begin
      state_nxt     = start_evt ? ADDR : IDLE;
      busy_nxt      = start_evt;
      bit_cnt_nxt   = '0;
      addressed_nxt = 1'b0;
      sda_oe_nxt    = 1'b0;
      scl_oe_nxt    = 1'b0;
      pend_nxt      = 1'b0;
      nack_nxt      = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_nxt = 4'd8;
            if (byte_in[7:1] == SLAVE_ADDR && byte_in[7:1] != 7'h00) begin
              rw_nxt        = byte_in[0];
              addressed_nxt = 1'b1;
              nack_nxt      = 1'b0;
              state_nxt     = ADDR_ACK;
            end else begin
              state_nxt = IGNORE;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shreg_nxt   = byte_in;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_nxt = 4'd8;
            state_nxt   = WR_ACK;
            nack_nxt    = 1'b0;
            if (!rx_full_i) begin
              rx_data_nxt  = byte_in;
              rx_valid_nxt = 1'b1;
            end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
              pend_nxt = 1'b1;
`else
              nack_nxt = 1'b1;
`endif
            end
          end
        end
        ADDR_ACK, WR_ACK, RD_ACK: begin
          // bit_cnt == 8 before the 9th rising edge, 0 after it.
          if (scl_oe_q) begin
            if (!rx_full_i) begin
              rx_data_nxt  = shreg;
              rx_valid_nxt = 1'b1;
              pend_nxt     = 1'b0;
              scl_oe_nxt   = 1'b0;
              sda_oe_nxt   = 1'b1;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (pend) begin
              if (rx_full_i) begin
                scl_oe_nxt = 1'b1;
              end else begin
                rx_data_nxt  = shreg;
                rx_valid_nxt = 1'b1;
                pend_nxt     = 1'b0;
                sda_oe_nxt   = 1'b1;
              end
            end else begin
              sda_oe_nxt = (state != RD_ACK) && !nack;
            end
          end else if (scl_rise && bit_cnt == 4'd8) begin
            bit_cnt_nxt = '0;
            if (state == RD_ACK) nack_nxt = sda_f;
          end else if (scl_fall && bit_cnt == 4'd0) begin
            sda_oe_nxt = 1'b0;
            if (nack) begin
              state_nxt = IGNORE;
            end else if (state == RD_ACK || (state == ADDR_ACK && rw_o)) begin
              state_nxt = RD_DATA;
              if (tx_valid_i) begin
                shreg_nxt    = tx_data_i;
                tx_taken_nxt = 1'b1;
                sda_oe_nxt   = ~tx_data_i[7];
              end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                scl_oe_nxt = 1'b1;
`else
                shreg_nxt = 8'hFF;
`endif
              end
            end else begin
              state_nxt = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_oe_q) begin
            if (tx_valid_i) begin
              shreg_nxt    = tx_data_i;
              tx_taken_nxt = 1'b1;
              sda_oe_nxt   = ~tx_data_i[7];
              scl_oe_nxt   = 1'b0;
            end
          end else if (scl_rise) begin
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt = 4'd8;
              state_nxt   = RD_ACK;
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end else if (scl_fall && bit_cnt != 4'd0) begin
            shreg_nxt  = {shreg[6:0], 1'b1};
            sda_oe_nxt = ~shreg[6];
          end
        end
        IGNORE:  sda_oe_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i2c_core_clock_i) begin
    shreg <= shreg_nxt;
    if (reset_i) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      busy_o      <= 1'b0;
      addressed_o <= 1'b0;
      rw_o        <= 1'b0;
      rx_data_o   <= 8'h00;
      rx_valid_o  <= 1'b0;
      tx_taken_o  <= 1'b0;
      nack        <= 1'b0;
      pend        <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      sda_oe_q    <= sda_oe_nxt;
      scl_oe_q    <= scl_oe_nxt;
      busy_o      <= busy_nxt;
      addressed_o <= addressed_nxt;
      rw_o        <= rw_nxt;
      rx_data_o   <= rx_data_nxt;
      rx_valid_o  <= rx_valid_nxt;
      tx_taken_o  <= tx_taken_nxt;
      nack        <= nack_nxt;
      pend        <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_slave_block.sv
// Directed bench for i2c_slave_block: a bit-banged I2C master over wired-AND lines.
`timescale 1ns/1ps
module tb_i2c_slave_block;
  localparam int Q = 10;  // quarter SCL period in core clocks

  logic       clk = 1'b0;
  logic       reset_i;
  logic       scl_m, sda_m, scl_line, sda_line;
  logic       scl_oe, sda_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_taken, rx_valid, rx_full;
  logic       busy, addressed, rw;
  int checks = 0, passed = 0;
  int rx_cnt = 0, tx_cnt = 0, sda_oe_cyc = 0, scl_oe_cyc = 0;

  always #5 clk = ~clk;
  assign scl_line = scl_m & ~scl_oe;
  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_block #(.SLAVE_ADDR(7'h50), .FILT_LEN(3)) dut (
    .i2c_core_clock_i(clk), .reset_i(reset_i), .scl_i(scl_line), .sda_i(sda_line),
    .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_taken_o(tx_taken), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_full_i(rx_full),
    .busy_o(busy), .addressed_o(addressed), .rw_o(rw)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_cnt <= rx_cnt + 1;
    if (tx_taken === 1'b1) tx_cnt <= tx_cnt + 1;
    if (sda_oe === 1'b1) sda_oe_cyc <= sda_oe_cyc + 1;
    if (scl_oe === 1'b1) scl_oe_cyc <= scl_oe_cyc + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_tx(input logic b, output logic s);
    int n;
    cyc(Q); sda_m = b; cyc(Q); scl_m = 1'b1;
    n = 0;
    while (scl_line !== 1'b1 && n < 2000) begin cyc(1); n++; end
    if (n >= 2000) begin
      checks++;
      $display("FAIL scl_release_timeout: scl still low after %0d cycles, limit 2000", n);
    end
    cyc(Q); s = sda_line; cyc(Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_tx(b[i], s);
    bit_tx(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin bit_tx(1'b1, s); d[i] = s; end
    bit_tx(~m_ack, s);
  endtask

  task automatic start_c;
    sda_m = 1'b0; cyc(2*Q); scl_m = 1'b0; cyc(Q);
  endtask

  task automatic stop_c;
    cyc(Q); sda_m = 1'b0; cyc(Q); scl_m = 1'b1; cyc(2*Q); sda_m = 1'b1; cyc(2*Q);
  endtask

  task automatic rstart_c;
    cyc(Q); sda_m = 1'b1; cyc(Q); scl_m = 1'b1; cyc(2*Q); sda_m = 1'b0; cyc(2*Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic test_reset;
    reset_i = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    tx_data = 8'hA5; tx_valid = 1'b1; rx_full = 1'b0;
    cyc(4);
    checks++; if (scl_oe !== 1'b0) $display("FAIL rst_scl_oe: got %b want 0", scl_oe); else passed++;
    checks++; if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe: got %b want 0", sda_oe); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if (addressed !== 1'b0) $display("FAIL rst_addressed: got %b want 0", addressed); else passed++;
    checks++; if (rw !== 1'b0) $display("FAIL rst_rw: got %b want 0", rw); else passed++;
    checks++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data: got %h want 00", rx_data); else passed++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", rx_valid); else passed++;
    checks++; if (tx_taken !== 1'b0) $display("FAIL rst_tx_taken: got %b want 0", tx_taken); else passed++;
    reset_i = 1'b0;
    cyc(10);
  endtask

  task automatic test_write;
    logic ack; int rx0;
    rx0 = rx_cnt;
    start_c;
    checks++; if (busy !== 1'b1) $display("FAIL wr_busy_start: got %b want 1", busy); else passed++;
    send_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) $display("FAIL wr_addr_ack: got %b want 1", ack); else passed++;
    checks++; if (addressed !== 1'b1 || rw !== 1'b0)
      $display("FAIL wr_addressed_rw: got %b%b want 10", addressed, rw); else passed++;
    send_byte(8'h3C, ack);
    checks++; if (ack !== 1'b1) $display("FAIL wr_data_ack: got %b want 1", ack); else passed++;
    checks++; if (rx_data !== 8'h3C) $display("FAIL wr_rx_data: got %h want 3c", rx_data); else passed++;
    checks++; if (rx_cnt - rx0 !== 1) $display("FAIL wr_rx_pulses: got %0d want 1", rx_cnt - rx0); else passed++;
    stop_c;
    checks++; if (busy !== 1'b0 || addressed !== 1'b0)
      $display("FAIL wr_after_stop: busy/addressed %b%b want 00", busy, addressed); else passed++;
  endtask

  task automatic test_mismatch;
    logic ack0, ack1; int rx0, oe0;
    rx0 = rx_cnt; oe0 = sda_oe_cyc;
    start_c;
    send_byte(8'hA2, ack0);
    send_byte(8'h55, ack1);
    checks++; if ({ack0, ack1} !== 2'b00) $display("FAIL mm_acks: got %b want 00", {ack0, ack1}); else passed++;
    checks++; if (sda_oe_cyc - oe0 !== 0) $display("FAIL mm_sda_pulled: got %0d cycles want 0", sda_oe_cyc - oe0); else passed++;
    checks++; if (rx_cnt - rx0 !== 0) $display("FAIL mm_rx_pulses: got %0d want 0", rx_cnt - rx0); else passed++;
    checks++; if (addressed !== 1'b0 || busy !== 1'b1)
      $display("FAIL mm_ignore: addressed/busy %b%b want 01", addressed, busy); else passed++;
    stop_c;
    checks++; if (busy !== 1'b0) $display("FAIL mm_busy_stop: got %b want 0", busy); else passed++;
  endtask

  task automatic test_read;
    logic ack; logic [7:0] d0, d1; int tx0;
    tx0 = tx_cnt; tx_data = 8'h96; tx_valid = 1'b1;
    start_c;
    send_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1 || rw !== 1'b1) $display("FAIL rd_addr: ack/rw %b%b want 11", ack, rw); else passed++;
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    checks++; if (d0 !== 8'h96) $display("FAIL rd_byte0: got %h want 96", d0); else passed++;
    checks++; if (d1 !== 8'h96) $display("FAIL rd_byte1: got %h want 96", d1); else passed++;
    checks++; if (tx_cnt - tx0 !== 2) $display("FAIL rd_tx_taken: got %0d want 2", tx_cnt - tx0); else passed++;
    stop_c;
    checks++; if (busy !== 1'b0 || sda_oe !== 1'b0)
      $display("FAIL rd_idle: busy/sda_oe %b%b want 00", busy, sda_oe); else passed++;
  endtask

`ifndef I2C_SLAVE_CLK_STRETCH_EN
  task automatic test_read_empty;
    logic ack; logic [7:0] d; int tx0;
    tx0 = tx_cnt; tx_valid = 1'b0;
    start_c;
    send_byte(8'hA1, ack);
    read_byte(1'b0, d);
    checks++; if (d !== 8'hFF) $display("FAIL rde_data: got %h want ff", d); else passed++;
    checks++; if (tx_cnt - tx0 !== 0) $display("FAIL rde_tx_taken: got %0d want 0", tx_cnt - tx0); else passed++;
    stop_c;
    tx_valid = 1'b1;
  endtask
`endif

  task automatic test_rx_full;
    logic ack; int rx0, so0;
    rx0 = rx_cnt; so0 = scl_oe_cyc;
    start_c;
    send_byte(8'hA0, ack);
    rx_full = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    fork begin cyc(300); rx_full = 1'b0; end join_none
    send_byte(8'h11, ack);
    checks++; if (ack !== 1'b1) $display("FAIL full_ack: got %b want 1", ack); else passed++;
    checks++; if (rx_cnt - rx0 !== 1 || rx_data !== 8'h11)
      $display("FAIL full_rx: pulses %0d data %h want 1 11", rx_cnt - rx0, rx_data); else passed++;
    checks++; if (scl_oe_cyc - so0 < 100) $display("FAIL full_stretch: got %0d cycles want >=100", scl_oe_cyc - so0); else passed++;
`else
    send_byte(8'h11, ack);
    checks++; if (ack !== 1'b0) $display("FAIL full_nack: got ack %b want 0", ack); else passed++;
    checks++; if (rx_cnt - rx0 !== 0) $display("FAIL full_rx: got %0d pulses want 0", rx_cnt - rx0); else passed++;
    checks++; if (scl_oe_cyc - so0 !== 0) $display("FAIL full_scl_oe: got %0d cycles want 0", scl_oe_cyc - so0); else passed++;
`endif
    rx_full = 1'b0;
    stop_c;
  endtask

  task automatic test_back_to_back;
    logic ack; logic [7:0] d; int rx0, tx0;
    rx0 = rx_cnt; tx0 = tx_cnt; tx_data = 8'h5A; tx_valid = 1'b1;
    start_c;
    send_byte(8'hA0, ack);
    send_byte(8'h01, ack);
    checks++; if (rx_data !== 8'h01 || rw !== 1'b0) $display("FAIL sr_first: data %h rw %b want 01 0", rx_data, rw); else passed++;
    rstart_c;
    checks++; if (busy !== 1'b1) $display("FAIL sr_busy: got %b want 1", busy); else passed++;
    send_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) $display("FAIL sr_addr_ack: got %b want 1", ack); else passed++;
    checks++; if (rw !== 1'b1 || addressed !== 1'b1)
      $display("FAIL sr_rw_addressed: got %b%b want 11", rw, addressed); else passed++;
    read_byte(1'b0, d);
    checks++; if (d !== 8'h5A) $display("FAIL sr_read: got %h want 5a", d); else passed++;
    checks++; if (rx_cnt - rx0 !== 1 || tx_cnt - tx0 !== 1)
      $display("FAIL sr_pulses: rx %0d tx %0d want 1 1", rx_cnt - rx0, tx_cnt - tx0); else passed++;
    stop_c;
  endtask

  task automatic test_reset_mid;
    logic ack, s; logic [7:0] d; int oe0;
    tx_data = 8'h00; tx_valid = 1'b1;
    start_c;
    send_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) bit_tx(1'b1, s);
    cyc(2*Q);
    checks++; if (sda_oe !== 1'b1) $display("FAIL rm_bit4_driven: got %b want 1", sda_oe); else passed++;
    reset_i = 1'b1; cyc(1); reset_i = 1'b0;
    checks++; if (sda_oe !== 1'b0 || busy !== 1'b0)
      $display("FAIL rm_release: sda_oe/busy %b%b want 00", sda_oe, busy); else passed++;
    scl_m = 1'b1; cyc(2*Q); scl_m = 1'b0;
    oe0 = sda_oe_cyc;
    read_byte(1'b1, d);
    checks++; if (sda_oe_cyc - oe0 !== 0 || d !== 8'hFF)
      $display("FAIL rm_ignored: oe cycles %0d data %h want 0 ff", sda_oe_cyc - oe0, d); else passed++;
    stop_c;
    start_c;
    send_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) $display("FAIL rm_new_start_ack: got %b want 1", ack); else passed++;
    stop_c;
  endtask

  initial begin
    test_reset;
    test_write;
    test_mismatch;
    test_read;
`ifndef I2C_SLAVE_CLK_STRETCH_EN
    test_read_empty;
`endif
    test_rx_full;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
